// File: rtl/unified_mem_responder.sv
// unified_mem_responder
//   Single-ported word memory shared by an instruction-fetch port and a data
//   port. Data requests have fixed priority over fetches. Each grant runs
//   IDLE -> ACCESS (LAT cycles) -> RESP -> IDLE, and the ack is registered
//   out of RESP, so grant-to-ack latency is LAT+1 cycles.
//   Loads and stores use RV32 funct3 size/sign codes with byte-lane selection.
//   Misaligned or illegal accesses raise d_err, suppress the store and zero
//   the load data.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset (array contents are kept)
//   if_req   : fetch request valid;  if_addr : fetch byte address
//   if_ack   : one-cycle fetch ack;  if_rdata : fetched word (held between acks)
//   d_req    : data request valid;   d_we : 1 = store, 0 = load
//   d_func   : funct3 size/sign;     d_addr : data byte address
//   d_wdata  : right-aligned store data
//   d_ack    : one-cycle data ack;   d_rdata : extended load data (held)
//   d_err    : error flag, valid only with d_ack
//   busy     : high whenever the FSM is not in IDLE
module unified_mem_responder #(
  parameter int unsigned DEPTH_W = 8,
  parameter int unsigned LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy
);

  localparam int unsigned WORDS = 1 << DEPTH_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request fields captured at grant
  logic        a_is_d;
  logic        a_we;
  logic [2:0]  a_func;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic [31:0] mem [WORDS];

  logic [DEPTH_W-1:0] idx;
  logic [1:0]         lane;
  logic [31:0]        rd_word;
  logic [31:0]        shifted;
  logic               err;
  logic [31:0]        ld_data;
  logic [31:0]        st_data;
  logic [3:0]         st_be;
  logic               unused_addr;

  assign idx         = a_addr[DEPTH_W+1:2];
  assign lane        = a_addr[1:0];
  assign rd_word     = mem[idx];
  assign unused_addr = ^a_addr[31:DEPTH_W+2];

  // Access decode on the captured request
  always_comb begin
    err     = 1'b0;
    ld_data = '0;
    st_data = '0;
    st_be   = '0;
    shifted = rd_word >> {lane, 3'b000};

    if (a_we) begin
      case (a_func)
        3'b000:  err = 1'b0;
        3'b001:  err = lane[0];
        3'b010:  err = |lane;
        default: err = 1'b1;
      endcase
    end else begin
      case (a_func)
        3'b000, 3'b100: err = 1'b0;
        3'b001, 3'b101: err = lane[0];
        3'b010:         err = |lane;
        default:        err = 1'b1;
      endcase
    end

    case (a_func)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b101:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = '0;
    endcase
    if (err) ld_data = '0;

    case (a_func[1:0])
      2'b00: begin
        st_data = {4{a_wdata[7:0]}};
        st_be   = 4'b0001 << lane;
      end
      2'b01: begin
        st_data = {2{a_wdata[15:0]}};
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = a_wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_is_d   <= 1'b0;
      a_we     <= 1'b0;
      a_func   <= '0;
      a_addr   <= '0;
      a_wdata  <= '0;
      if_ack   <= 1'b0;
      if_rdata <= '0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req) begin
            a_is_d  <= 1'b1;
            a_we    <= d_we;
            a_func  <= d_func;
            a_addr  <= d_addr;
            a_wdata <= d_wdata;
            cnt     <= 4'(LAT - 1);
            state   <= ACCESS;
            busy    <= 1'b1;
          end else if (if_req) begin
            a_is_d  <= 1'b0;
            a_we    <= 1'b0;
            a_func  <= 3'b010;
            a_addr  <= if_addr;
            a_wdata <= '0;
            cnt     <= 4'(LAT - 1);
            state   <= ACCESS;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          busy <= 1'b1;
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 4'd1;
        end
        RESP: begin
          // Ack is raised on the edge leaving RESP, giving LAT+1 cycle latency
          state <= IDLE;
          busy  <= 1'b0;
          if (a_is_d) begin
            d_ack <= 1'b1;
            d_err <= err;
            if (!a_we) d_rdata <= ld_data;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= rd_word;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; a reset during ACCESS leaves state IDLE so no write
  always_ff @(posedge clk) begin
    if (state == RESP && a_is_d && a_we && !err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
module tb_unified_mem_responder;

  localparam int unsigned DEPTH_W = 8;
  localparam int unsigned LAT     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_func = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        busy;

  unified_mem_responder #(.DEPTH_W(DEPTH_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t d_q[$];
  exp_t if_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Byte-addressed shadow of the 1 KiB array
  logic [7:0] mb [1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f, input logic [31:0] a);
    logic size_ok;
    size_ok = (f[1:0] == 2'b00) ||
              (f[1:0] == 2'b01 && a[0] == 1'b0) ||
              (f[1:0] == 2'b10 && a[1:0] == 2'b00);
    if (we) return !(f == 3'd0 || f == 3'd1 || f == 3'd2) || !size_ok;
    return !(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5) || !size_ok;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    logic [9:0]  b;
    logic [7:0]  by;
    logic [15:0] hw;
    b  = a[9:0];
    by = mb[b];
    hw = {mb[{b[9:1], 1'b1}], mb[{b[9:1], 1'b0}]};
    case (f)
      3'd0:    return by[7] ? {24'hFFFFFF, by} : {24'h0, by};
      3'd1:    return hw[15] ? {16'hFFFF, hw} : {16'h0, hw};
      3'd2:    return model_word(a);
      3'd4:    return {24'h0, by};
      3'd5:    return {16'h0, hw};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    logic [9:0] b;
    b = a[9:0];
    case (f)
      3'd0: mb[b] = w[7:0];
      3'd1: begin mb[b] = w[7:0]; mb[b+1] = w[15:8]; end
      default: begin
        mb[b] = w[7:0]; mb[b+1] = w[15:8]; mb[b+2] = w[23:16]; mb[b+3] = w[31:24];
      end
    endcase
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (d_ack) begin
      if (d_q.size() == 0) check("d_ack_unexpected", {31'b0, d_ack}, 32'd0);
      else begin
        exp_t e;
        e = d_q.pop_front();
        check("d_err", {31'b0, d_err}, {31'b0, e.err});
        if (e.chk) check("d_rdata", d_rdata, e.data);
      end
    end else if (d_err) begin
      check("d_err_no_ack", {31'b0, d_err}, 32'd0);
    end
    if (if_ack) begin
      if (if_q.size() == 0) check("if_ack_unexpected", {31'b0, if_ack}, 32'd0);
      else begin
        exp_t e;
        e = if_q.pop_front();
        check("if_rdata", if_rdata, e.data);
      end
    end
  end

  task automatic d_txn(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] w, input string tag);
    exp_t e;
    int   n;
    e.err  = model_err(we, f, a);
    e.chk  = !we;
    e.data = we ? 32'h0 : (e.err ? 32'h0 : model_load(f, a));
    if (we && !e.err) model_store(f, a, w);
    d_q.push_back(e);
    d_req = 1'b1; d_we = we; d_func = f; d_addr = a; d_wdata = w;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!d_ack && n < 30);
    check({tag, "_latency"}, 32'(n - 1), 32'(LAT + 1));
    d_req = 1'b0;
  endtask

  task automatic f_txn(input logic [31:0] a, input string tag);
    exp_t e;
    int   n;
    e.err = 1'b0; e.chk = 1'b1; e.data = model_word(a);
    if_q.push_back(e);
    if_req = 1'b1; if_addr = a;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!if_ack && n < 30);
    check({tag, "_latency"}, 32'(n - 1), 32'(LAT + 1));
    if_req = 1'b0;
  endtask

  task automatic both_txn();
    exp_t e;
    int   n;
    int   low;
    e.err = 1'b0; e.chk = 1'b1; e.data = model_load(3'd2, 32'h10);
    d_q.push_back(e);
    e.data = model_word(32'h24);
    if_q.push_back(e);
    d_req = 1'b1; d_we = 1'b0; d_func = 3'd2; d_addr = 32'h10; d_wdata = '0;
    if_req = 1'b1; if_addr = 32'h24;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!d_ack && n < 30);
    check("prio_d_first", {31'b0, d_ack}, 32'd1);
    check("prio_if_not_yet", {31'b0, if_ack}, 32'd0);
    check("prio_d_latency", 32'(n - 1), 32'(LAT + 1));
    d_req = 1'b0;
    low = busy ? 0 : 1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!if_ack && !busy) low++;
    end while (!if_ack && n < 30);
    check("prio_if_gap", 32'(n), 32'(LAT + 2));
    check("prio_busy_low_cycles", 32'(low), 32'd1);
    if_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_d_ack", {31'b0, d_ack}, 32'd0);
    check("rst_if_ack", {31'b0, if_ack}, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    d_txn(1'b1, 3'd2, 32'h10, 32'h8000_00F1, "sw");
    d_txn(1'b0, 3'd2, 32'h10, 32'h0, "lw");
    d_txn(1'b0, 3'd0, 32'h13, 32'h0, "lb");
    d_txn(1'b0, 3'd4, 32'h13, 32'h0, "lbu");
    d_txn(1'b0, 3'd1, 32'h12, 32'h0, "lh");
    d_txn(1'b0, 3'd5, 32'h10, 32'h0, "lhu");
    d_txn(1'b1, 3'd0, 32'h11, 32'h0000_00AB, "sb");
    d_txn(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_sb");
    d_txn(1'b1, 3'd1, 32'h12, 32'h0000_1234, "sh");
    d_txn(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_sh");

    // Error cases
    d_txn(1'b1, 3'd2, 32'h16, 32'hFFFF_FFFF, "sw_mis");
    d_txn(1'b1, 3'd1, 32'h11, 32'h0000_5555, "sh_mis");
    d_txn(1'b1, 3'd3, 32'h10, 32'h1111_1111, "st_bad_func");
    d_txn(1'b0, 3'd2, 32'h10, 32'h0, "lw_unchanged");
    d_txn(1'b0, 3'd2, 32'h16, 32'h0, "lw_mis");
    d_txn(1'b0, 3'd1, 32'h13, 32'h0, "lh_mis");
    d_txn(1'b0, 3'd3, 32'h10, 32'h0, "ld_func011");
    d_txn(1'b0, 3'd6, 32'h10, 32'h0, "ld_func110");

    // Fetch coherence with a just-stored word, low address bits ignored
    d_txn(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, "sw_20");
    f_txn(32'h23, "fetch_20");
    d_txn(1'b1, 3'd2, 32'h24, 32'hCAFE_0123, "sw_24");

    both_txn();

    // Reset in the middle of ACCESS
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_func = 3'd2; d_addr = 32'h10;
    @(posedge clk); #3;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_ack", {31'b0, d_ack}, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_ack_after", {31'b0, d_ack}, 32'd0);

    f_txn(32'h410, "fetch_wrap");

    repeat (4) @(posedge clk);
    #1;
    check("d_q_drained", 32'(d_q.size()), 32'd0);
    check("if_q_drained", 32'(if_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
